rx_buffer_memory: RTL and testbench
===================================

Name: rx_buffer_memory

Overview:
- Receive-side packet buffer between the 1G MAC receive path and the PL/host read interface.
- The MAC writes each received frame into a free slot, full-width and byte-masked. It then commits the frame with its byte length, or it is refused when no slot is free.
- The PL walks committed slots in FIFO order. It reads 1/2/4/8-byte quantities with one-cycle latency, extracted and zero-extended, then releases the slot.

Parameters:
- slot_p, 2, number of frame slots (power of two, >=2)
- data_width_p, 64, memory word width in bits; 32 or 64 only
- els_lp (local), 2048, bytes per slot
- addr_width_lp (local), 11, byte address width within a slot
- size_width_lp (local), 16, frame length field width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- write_slot_ready_o  out  1  a free slot exists (not full); MAC may write/commit
- write_v_i  in  1  write one word into current write slot
- write_addr_i  in  11  byte address, must be word-aligned
- write_data_i  in  data_width_p  write data
- write_mask_i  in  data_width_p/8  byte enables
- write_commit_v_i  in  1  frame complete: latch size, enqueue slot
- write_size_i  in  16  frame length in bytes
- read_slot_v_o  out  1  a committed slot is available (not empty)
- read_size_r_o  out  16  length of head slot, valid when read_slot_v_o
- read_slot_release_i  in  1  dequeue head slot
- read_v_i  in  1  read request on head slot
- read_addr_i  in  11  byte address
- read_op_size_i  in  2  0=1B 1=2B 2=4B 3=8B
- read_data_v_o  out  1  read data valid
- read_data_r_o  out  data_width_p  extracted, zero-extended read data
- read_misaligned_r_o  out  1  sticky misaligned/illegal read flag
- drop_count_r_o  out  16  saturating count of refused frames
- drop_count_clear_i  in  1  clear drop counter and misaligned flag

Behaviour:
- Reset (async): all slots empty, pointers 0, read_slot_v_o=0, write_slot_ready_o=1, read_data_v_o=0, read_data_r_o=0, read_misaligned_r_o=0, drop_count_r_o=0, sizes 0. Any in-flight read is discarded.
- Slot tracking: wptr/rptr mod slot_p plus full/empty. Enqueue = write_commit_v_i & write_slot_ready_o. Dequeue = read_slot_release_i & read_slot_v_o. Simultaneous enqueue and dequeue is legal in every state. Release when empty is ignored.
- MAC writes go to slot[wptr] only when write_slot_ready_o. A write while full is ignored.
- Commit while full: ignored; drop_count increments (saturates at 0xFFFF).
- Write and commit in the same cycle: the write lands first, then the size latches.
- Read acceptance = read_v_i & read_slot_v_o. Slot[rptr] is read at word address read_addr_i[10:lsb]. A read while empty is ignored, and read_data_v_o stays 0 next cycle.
- Read latency: exactly 1 cycle. The cycle after acceptance, read_data_v_o=1 and read_data_r_o = (word >> 8*offset) masked to the op size, zero-extended.
  - Offset, op size and slot index are registered at acceptance.
  - read_data_r_o holds its value until the next accepted read.
- Read and release in the same cycle: the read uses the pre-release slot and returns its data.
- MAC write and PL read of different slots in the same cycle: independent, no stall.
- Misaligned read (2B addr[0]!=0; 4B addr[1:0]!=0; 8B addr[2:0]!=0; op 3 with data_width_p=32): data returned is 0, read_data_v_o still 1, read_misaligned_r_o sets.
- drop_count_clear_i clears the counter and the flag. If it coincides with a drop, the result is 1.
- read_size_r_o is combinational from slot[rptr] size.
- Simulation-only assertions: data_width_p legal; MAC write address aligned.

Decomposition:
- Package rx_buffer_pkg holds:
  - constants els, addr width, size width
  - op-size enum (op_1b/op_2b/op_4b/op_8b)
  - an alignment-check function shared with tx_buffer_memory.
- Sub-module rx_slot_tracker: async-reset FIFO pointer/full/empty tracker with one-hot rptr/wptr outputs.
- Per-slot storage uses bsg_mem_1rw_sync_mask_write_byte.

Test Plan:
- Reset, then write 8 words of 0x0706050403020100+0x0808080808080808*k at addr 8k, commit size 64 -> read_slot_v_o=1, read_size_r_o=64, write_slot_ready_o=1.
- 1B read addr 5 -> next cycle read_data_r_o=0x05. 2B addr 6 -> 0x0706. 4B addr 12 -> 0x0F0E0D0C. 8B addr 16 -> 0x1716151413121110.
- Fill both slots (slot_p=2), then commit a third frame -> write_slot_ready_o=0, drop_count_r_o=1. Release, then commit -> enqueue accepted, count stays 1.
- Read addr 0 with release in the same cycle on slot 0 -> data from slot 0. rptr advances, and read_size_r_o shows slot 1's size.
- 2B read at addr 3 -> read_data_r_o=0, read_misaligned_r_o=1. drop_count_clear_i -> flag and counter 0.
- Assert reset between read acceptance and data return -> read_data_v_o=0, all outputs at reset values, read_slot_v_o=0.

Source files
------------

// File: rtl/rx_buffer_pkg.sv
// Shared constants, read op-size encoding and alignment check for the rx/tx packet buffers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_buffer_pkg;

  localparam int els_lp        = 2048;  // bytes per slot
  localparam int addr_width_lp = 11;    // byte address within a slot
  localparam int size_width_lp = 16;    // frame length field

  typedef enum logic [1:0] {
    op_1b = 2'd0,
    op_2b = 2'd1,
    op_4b = 2'd2,
    op_8b = 2'd3
  } op_size_e;

  // True when a read of the given size at this byte address lands on its
  // natural boundary and fits in one memory word of data_width bits.
  function automatic logic op_aligned(input logic [2:0] addr_lo,
                                      input op_size_e   op,
                                      input int         data_width);
    logic ok;
    ok = 1'b0;
    case (op)
      op_1b:   ok = 1'b1;
      op_2b:   ok = (addr_lo[0] == 1'b0);
      op_4b:   ok = (addr_lo[1:0] == 2'b00);
      op_8b:   ok = (data_width == 64) && (addr_lo == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables.
// Latency: read data on data_o one cycle after a read access; data_o holds until the next read.
// Backpressure: none; one access (read or write) per cycle.
// Ports: clk_i; v_i access enable; w_i 1=write 0=read; addr_i word address;
//        data_i/write_mask_i write data and byte enables; data_o registered read data.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter  int width_p       = 64,
  parameter  int els_p         = 256,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int bytes_lp      = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [bytes_lp-1:0]      write_mask_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (write_mask_i[b]) mem[addr_i][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
    if (v_i & ~w_i) data_o <= mem[addr_i];
  end

endmodule

// File: rtl/rx_slot_tracker.sv
// Ring-order slot allocator: write/read pointers with full/empty, binary and one-hot views.
// Latency: pointer and flag updates visible the cycle after enq_i/deq_i.
// Backpressure: callers must qualify enq_i with ~full_o and deq_i with ~empty_o.
// Ports: clk_i, reset_i (async, active high); enq_i/deq_i qualified strobes;
//        full_o/empty_o; wptr_o/rptr_o slot indices; *_one_hot_o decoded indices.
module rx_slot_tracker
  import rx_buffer_pkg::*;
#(
  parameter  int slot_p       = 2,
  localparam int ptr_width_lp = $clog2(slot_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enq_i,
  input  logic                    deq_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [ptr_width_lp-1:0] wptr_o,
  output logic [ptr_width_lp-1:0] rptr_o,
  output logic [slot_p-1:0]       wptr_one_hot_o,
  output logic [slot_p-1:0]       rptr_one_hot_o
);

  // slot_p is a power of two, so pointer overflow is the modulo wrap.
  logic [ptr_width_lp-1:0] wptr_inc, rptr_inc;
  assign wptr_inc = wptr_o + 1'b1;
  assign rptr_inc = rptr_o + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_o  <= '0;
      rptr_o  <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (enq_i) wptr_o <= wptr_inc;
      if (deq_i) rptr_o <= rptr_inc;
      // Simultaneous enq/deq keeps occupancy, so both flags hold.
      if (enq_i & ~deq_i) begin
        empty_o <= 1'b0;
        full_o  <= (wptr_inc == rptr_o);
      end else if (deq_i & ~enq_i) begin
        full_o  <= 1'b0;
        empty_o <= (rptr_inc == wptr_o);
      end
    end
  end

  assign wptr_one_hot_o = slot_p'(1) << wptr_o;
  assign rptr_one_hot_o = slot_p'(1) << rptr_o;

endmodule

// File: rtl/rx_buffer_memory.sv
// Receive packet buffer: MAC fills and commits frame slots, PL reads committed slots in order.
// Latency: read data 1 cycle after an accepted read; commit visible to reader next cycle.
// Backpressure: write_slot_ready_o low when all slots committed (commits dropped and counted);
//               reads/releases ignored while read_slot_v_o is low.
// Ports: MAC side write_v_i/addr/data/mask + write_commit_v_i/write_size_i;
//        PL side read_slot_v_o/read_size_r_o/read_slot_release_i, read_v_i/addr/op_size,
//        read_data_v_o/read_data_r_o/read_misaligned_r_o; drop_count_r_o/drop_count_clear_i.
module rx_buffer_memory
  import rx_buffer_pkg::*;
#(
  parameter int slot_p       = 2,
  parameter int data_width_p = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       write_slot_ready_o,
  input  logic                       write_v_i,
  input  logic [addr_width_lp-1:0]   write_addr_i,
  input  logic [data_width_p-1:0]    write_data_i,
  input  logic [data_width_p/8-1:0]  write_mask_i,
  input  logic                       write_commit_v_i,
  input  logic [size_width_lp-1:0]   write_size_i,
  output logic                       read_slot_v_o,
  output logic [size_width_lp-1:0]   read_size_r_o,
  input  logic                       read_slot_release_i,
  input  logic                       read_v_i,
  input  logic [addr_width_lp-1:0]   read_addr_i,
  input  logic [1:0]                 read_op_size_i,
  output logic                       read_data_v_o,
  output logic [data_width_p-1:0]    read_data_r_o,
  output logic                       read_misaligned_r_o,
  output logic [15:0]                drop_count_r_o,
  input  logic                       drop_count_clear_i
);

  localparam int bytes_lp     = data_width_p / 8;
  localparam int lsb_lp       = $clog2(bytes_lp);
  localparam int words_lp     = els_lp / bytes_lp;
  localparam int ptr_width_lp = $clog2(slot_p);

  logic full, empty;
  logic enq, deq, write_acc, read_acc, drop;
  logic [ptr_width_lp-1:0] wptr, rptr;
  logic [slot_p-1:0]       wptr_oh, rptr_oh;

  assign write_slot_ready_o = ~full;
  assign read_slot_v_o      = ~empty;
  assign enq       = write_commit_v_i & write_slot_ready_o;
  assign deq       = read_slot_release_i & read_slot_v_o;
  assign write_acc = write_v_i & write_slot_ready_o;
  assign read_acc  = read_v_i & read_slot_v_o;
  assign drop      = write_commit_v_i & full;

  rx_slot_tracker #(.slot_p(slot_p)) tracker (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .enq_i          (enq),
    .deq_i          (deq),
    .full_o         (full),
    .empty_o        (empty),
    .wptr_o         (wptr),
    .rptr_o         (rptr),
    .wptr_one_hot_o (wptr_oh),
    .rptr_one_hot_o (rptr_oh)
  );

  // Writer owns slot[wptr] (uncommitted), reader owns slot[rptr] (committed).
  // They only coincide when full or empty, where one side is blocked, so each
  // single-port slot RAM sees at most one access per cycle.
  logic [data_width_p-1:0] mem_q [slot_p];

  for (genvar i = 0; i < slot_p; i++) begin : g_slot
    logic wr, rd;
    assign wr = write_acc & wptr_oh[i];
    assign rd = read_acc & rptr_oh[i];

    bsg_mem_1rw_sync_mask_write_byte #(
      .width_p (data_width_p),
      .els_p   (words_lp)
    ) mem (
      .clk_i        (clk_i),
      .v_i          (wr | rd),
      .w_i          (wr),
      .addr_i       (wr ? write_addr_i[addr_width_lp-1:lsb_lp]
                        : read_addr_i[addr_width_lp-1:lsb_lp]),
      .data_i       (write_data_i),
      .write_mask_i (write_mask_i),
      .data_o       (mem_q[i])
    );
  end

  // Frame lengths, latched on enqueue.
  logic [size_width_lp-1:0] size_r [slot_p];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < slot_p; i++) size_r[i] <= '0;
    end else if (enq) begin
      size_r[wptr] <= write_size_i;
    end
  end

  assign read_size_r_o = size_r[rptr];

  // Read request decode and the state carried to the data-return cycle.
  op_size_e read_op;
  logic     read_ok;
  assign read_op = op_size_e'(read_op_size_i);
  assign read_ok = op_aligned(read_addr_i[2:0], read_op, data_width_p);

  logic                    rd_v_r, rd_bad_r, mis_r;
  op_size_e                rd_op_r;
  logic [lsb_lp-1:0]       rd_offset_r;
  logic [ptr_width_lp-1:0] rd_slot_r;
  logic [data_width_p-1:0] data_hold_r, shifted, extracted;
  logic [15:0]             drop_r;

  always_comb begin
    shifted   = mem_q[rd_slot_r] >> {rd_offset_r, 3'b000};
    extracted = '0;
    if (!rd_bad_r) begin
      case (rd_op_r)
        op_1b:   extracted = data_width_p'(shifted[7:0]);
        op_2b:   extracted = data_width_p'(shifted[15:0]);
        op_4b:   extracted = data_width_p'(shifted[31:0]);
        default: extracted = shifted;
      endcase
    end
  end

  // The RAM output may move once its slot is reused, so the returned word is
  // captured to keep read_data_r_o stable until the next accepted read.
  assign read_data_v_o       = rd_v_r;
  assign read_data_r_o       = rd_v_r ? extracted : data_hold_r;
  assign read_misaligned_r_o = mis_r;
  assign drop_count_r_o      = drop_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_v_r      <= 1'b0;
      rd_bad_r    <= 1'b0;
      rd_op_r     <= op_1b;
      rd_offset_r <= '0;
      rd_slot_r   <= '0;
      data_hold_r <= '0;
      mis_r       <= 1'b0;
      drop_r      <= '0;
    end else begin
      rd_v_r <= read_acc;
      if (read_acc) begin
        rd_bad_r    <= ~read_ok;
        rd_op_r     <= read_op;
        rd_offset_r <= read_addr_i[lsb_lp-1:0];
        rd_slot_r   <= rptr;
      end
      if (rd_v_r) data_hold_r <= extracted;

      // A new misaligned read wins over a coincident clear.
      if (drop_count_clear_i)    mis_r <= 1'b0;
      if (read_acc & ~read_ok)   mis_r <= 1'b1;

      if (drop_count_clear_i)          drop_r <= drop ? 16'd1 : 16'd0;
      else if (drop && drop_r != '1)   drop_r <= drop_r + 16'd1;
    end
  end

  assert property (@(posedge clk_i) (data_width_p == 32) || (data_width_p == 64));
  assert property (@(posedge clk_i) disable iff (reset_i)
                   write_acc |-> (write_addr_i[lsb_lp-1:0] == '0));

endmodule

// File: tb/tb_rx_buffer_memory.sv
module tb_rx_buffer_memory;
  import rx_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        write_slot_ready_o, write_v_i, write_commit_v_i;
  logic [10:0] write_addr_i, read_addr_i;
  logic [63:0] write_data_i, read_data_r_o;
  logic [7:0]  write_mask_i;
  logic [15:0] write_size_i, read_size_r_o, drop_count_r_o;
  logic        read_slot_v_o, read_slot_release_i, read_v_i;
  logic [1:0]  read_op_size_i;
  logic        read_data_v_o, read_misaligned_r_o, drop_count_clear_i;

  rx_buffer_memory #(.slot_p(2), .data_width_p(64)) dut (
    .clk_i               (clk),
    .reset_i             (rst),
    .write_slot_ready_o  (write_slot_ready_o),
    .write_v_i           (write_v_i),
    .write_addr_i        (write_addr_i),
    .write_data_i        (write_data_i),
    .write_mask_i        (write_mask_i),
    .write_commit_v_i    (write_commit_v_i),
    .write_size_i        (write_size_i),
    .read_slot_v_o       (read_slot_v_o),
    .read_size_r_o       (read_size_r_o),
    .read_slot_release_i (read_slot_release_i),
    .read_v_i            (read_v_i),
    .read_addr_i         (read_addr_i),
    .read_op_size_i      (read_op_size_i),
    .read_data_v_o       (read_data_v_o),
    .read_data_r_o       (read_data_r_o),
    .read_misaligned_r_o (read_misaligned_r_o),
    .drop_count_r_o      (drop_count_r_o),
    .drop_count_clear_i  (drop_count_clear_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Byte-addressed slot contents, a queue of committed (slot, size) in arrival
  // order, and the slot the MAC is currently filling.
  logic [7:0]  m_mem [2][2048];
  int          q_slot[$];
  int          q_sz[$];
  int          m_wslot = 0;
  logic        m_dv    = 1'b0;
  logic [63:0] m_data  = '0;
  logic        m_mis   = 1'b0;
  int          m_drop  = 0;
  int          n, s;
  logic        full0, m_drop_now, m_bad;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q_slot.delete();
      q_sz.delete();
      m_wslot = 0;
      m_dv    = 1'b0;
      m_data  = '0;
      m_mis   = 1'b0;
      m_drop  = 0;
    end else begin
      full0 = (q_slot.size() == 2);
      m_bad = 1'b0;
      if (read_v_i && q_slot.size() > 0) begin
        n = 1 << read_op_size_i;
        s = q_slot[0];
        m_dv   = 1'b1;
        m_data = '0;
        if ((int'(read_addr_i) % n) != 0) m_bad = 1'b1;
        else for (int i = 0; i < n; i++)
          m_data = m_data | (64'(m_mem[s][int'(read_addr_i) + i]) << (8 * i));
      end else begin
        m_dv = 1'b0;
      end
      if (write_v_i && !full0)
        for (int j = 0; j < 8; j++)
          if (write_mask_i[j]) m_mem[m_wslot][int'(write_addr_i) + j] = write_data_i[8*j +: 8];
      m_drop_now = write_commit_v_i && full0;
      if (read_slot_release_i && q_slot.size() > 0) begin
        void'(q_slot.pop_front());
        void'(q_sz.pop_front());
      end
      if (write_commit_v_i && !full0) begin
        q_slot.push_back(m_wslot);
        q_sz.push_back(int'(write_size_i));
        m_wslot = (m_wslot + 1) % 2;
      end
      if (drop_count_clear_i) m_mis = 1'b0;
      if (m_bad) m_mis = 1'b1;
      if (drop_count_clear_i) m_drop = m_drop_now ? 1 : 0;
      else if (m_drop_now && m_drop < 65535) m_drop++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ready", 64'(write_slot_ready_o), 64'(q_slot.size() < 2));
    chk("slot_v", 64'(read_slot_v_o), 64'(q_slot.size() > 0));
    if (q_sz.size() > 0) chk("size", 64'(read_size_r_o), 64'(q_sz[0]));
    chk("data_v", 64'(read_data_v_o), 64'(m_dv));
    chk("data", read_data_r_o, m_data);
    chk("misal", 64'(read_misaligned_r_o), 64'(m_mis));
    chk("drop", 64'(drop_count_r_o), 64'(m_drop));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mac(input logic wv, input logic [10:0] addr, input logic [63:0] data,
                     input logic [7:0] mask, input logic commit, input logic [15:0] size);
    write_v_i        = wv;
    write_addr_i     = addr;
    write_data_i     = data;
    write_mask_i     = mask;
    write_commit_v_i = commit;
    write_size_i     = size;
    tick();
    write_v_i        = 1'b0;
    write_commit_v_i = 1'b0;
  endtask

  // Issue one read (optionally with release); returns at the data cycle.
  task automatic rd(input logic [10:0] addr, input op_size_e op, input logic rel);
    read_v_i            = 1'b1;
    read_addr_i         = addr;
    read_op_size_i      = op;
    read_slot_release_i = rel;
    tick();
    read_v_i            = 1'b0;
    read_slot_release_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    write_v_i = 0; write_addr_i = 0; write_data_i = 0; write_mask_i = 0;
    write_commit_v_i = 0; write_size_i = 0; read_slot_release_i = 0;
    read_v_i = 0; read_addr_i = 0; read_op_size_i = 0; drop_count_clear_i = 0;

    @(negedge clk);
    chk("rst_ready", 64'(write_slot_ready_o), 64'd1);
    chk("rst_slot_v", 64'(read_slot_v_o), 64'd0);
    chk("rst_data_v", 64'(read_data_v_o), 64'd0);
    chk("rst_data", read_data_r_o, 64'd0);
    chk("rst_drop", 64'(drop_count_r_o), 64'd0);
    chk("rst_size", 64'(read_size_r_o), 64'd0);
    tick();
    rst = 1'b0;

    // Frame A into slot 0; last word written together with the commit.
    for (int k = 0; k < 8; k++)
      mac(1'b1, 11'(8 * k), 64'h0706050403020100 + 64'(k) * 64'h0808080808080808,
          8'hFF, k == 7, 16'd64);
    @(negedge clk);
    chk("a_slot_v", 64'(read_slot_v_o), 64'd1);
    chk("a_size", 64'(read_size_r_o), 64'd64);
    chk("a_ready", 64'(write_slot_ready_o), 64'd1);

    rd(11'd5, op_1b, 1'b0);  chk("rd1b_5", read_data_r_o, 64'h05);
    rd(11'd6, op_2b, 1'b0);  chk("rd2b_6", read_data_r_o, 64'h0706);
    rd(11'd12, op_4b, 1'b0); chk("rd4b_12", read_data_r_o, 64'h0F0E0D0C);
    rd(11'd16, op_8b, 1'b0); chk("rd8b_16", read_data_r_o, 64'h1716151413121110);
    rd(11'd62, op_2b, 1'b0); chk("rd2b_62", read_data_r_o, 64'h3F3E);
    tick();
    @(negedge clk);
    chk("hold_v", 64'(read_data_v_o), 64'd0);
    chk("hold_data", read_data_r_o, 64'h3F3E);

    // Frame B into slot 1 with a partial mask -> full.
    mac(1'b1, 11'd0, 64'hA0A1A2A3A4A5A6A7, 8'h0F, 1'b1, 16'd100);
    @(negedge clk);
    chk("full_ready", 64'(write_slot_ready_o), 64'd0);
    mac(1'b1, 11'd0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 16'd0);  // ignored while full
    mac(1'b0, 11'd0, 64'd0, 8'h00, 1'b1, 16'd5);                 // dropped
    @(negedge clk);
    chk("drop1", 64'(drop_count_r_o), 64'd1);

    // Read slot 0 while releasing it: pre-release slot data, then slot 1 size.
    rd(11'd0, op_8b, 1'b1);
    chk("rel_data", read_data_r_o, 64'h0706050403020100);
    chk("rel_size", 64'(read_size_r_o), 64'd100);
    chk("rel_ready", 64'(write_slot_ready_o), 64'd1);

    mac(1'b1, 11'd0, 64'h1122334455667788, 8'hFF, 1'b1, 16'd8);
    @(negedge clk);
    chk("refill_ready", 64'(write_slot_ready_o), 64'd0);
    chk("refill_drop", 64'(drop_count_r_o), 64'd1);

    rd(11'd0, op_4b, 1'b0); chk("b_rd4b_0", read_data_r_o, 64'hA4A5A6A7);
    rd(11'd2, op_1b, 1'b0); chk("b_rd1b_2", read_data_r_o, 64'hA5);
    rd(11'd3, op_2b, 1'b0);
    chk("mis_data", read_data_r_o, 64'd0);
    chk("mis_v", 64'(read_data_v_o), 64'd1);
    chk("mis_flag", 64'(read_misaligned_r_o), 64'd1);

    // Release and commit together while full: commit still refused.
    read_slot_release_i = 1'b1;
    mac(1'b0, 11'd0, 64'd0, 8'h00, 1'b1, 16'd7);
    read_slot_release_i = 1'b0;
    @(negedge clk);
    chk("fullrc_drop", 64'(drop_count_r_o), 64'd2);
    chk("fullrc_size", 64'(read_size_r_o), 64'd8);

    // Release and commit together with one slot held.
    mac(1'b1, 11'd0, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0, 16'd0);
    read_slot_release_i = 1'b1;
    mac(1'b0, 11'd0, 64'd0, 8'h00, 1'b1, 16'd16);
    read_slot_release_i = 1'b0;
    @(negedge clk);
    chk("rc_size", 64'(read_size_r_o), 64'd16);
    chk("rc_ready", 64'(write_slot_ready_o), 64'd1);
    rd(11'd0, op_8b, 1'b0); chk("rc_data", read_data_r_o, 64'hDEADBEEFCAFEF00D);

    drop_count_clear_i = 1'b1;
    tick();
    drop_count_clear_i = 1'b0;
    @(negedge clk);
    chk("clr_drop", 64'(drop_count_r_o), 64'd0);
    chk("clr_flag", 64'(read_misaligned_r_o), 64'd0);

    // Clear coinciding with a drop leaves the count at 1.
    mac(1'b1, 11'd0, 64'h55, 8'hFF, 1'b1, 16'd24);
    drop_count_clear_i = 1'b1;
    mac(1'b0, 11'd0, 64'd0, 8'h00, 1'b1, 16'd9);
    drop_count_clear_i = 1'b0;
    @(negedge clk);
    chk("clrdrop", 64'(drop_count_r_o), 64'd1);

    // Reset between acceptance and data return.
    read_v_i = 1'b1; read_addr_i = 11'd0; read_op_size_i = op_1b;
    tick();
    read_v_i = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rr_data_v", 64'(read_data_v_o), 64'd0);
    chk("rr_data", read_data_r_o, 64'd0);
    chk("rr_slot_v", 64'(read_slot_v_o), 64'd0);
    chk("rr_ready", 64'(write_slot_ready_o), 64'd1);
    chk("rr_drop", 64'(drop_count_r_o), 64'd0);
    tick();
    rst = 1'b0;

    // Read while empty is ignored.
    rd(11'd0, op_1b, 1'b0);
    chk("empty_rd_v", 64'(read_data_v_o), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
